// File: rtl/payload_match_reporter.sv
// payload_match_reporter
//
// Waits for the end of a payload, lets the engine pipeline drain, samples the
// sticky match vector of the engine bank, clears the engines for the next
// payload, then streams out the IDs of the matching engines lowest-first over a
// valid/ready interface. After the stream it pulses done and reports how many
// IDs were sent.
//
// Ports
//   clk           single clock
//   reset         synchronous, active-high reset
//   match_in      sticky match outputs, one bit per engine (bit index = ID)
//   eop_in        one-cycle pulse, last payload byte presented to engines
//   eng_clr       one-cycle clear to the engine sod inputs (in the capture cycle)
//   rpt_valid     report ID valid
//   rpt_ready     consumer accepts the ID
//   rpt_id        index of a matching engine
//   rpt_last      final ID for this payload (qualifies rpt_valid)
//   done          one-cycle pulse, reporting for the payload is complete
//   match_cnt     IDs reported for the last payload, held until the next capture
//   busy          high in every state except IDLE
//   err_eop_drop  sticky, an eop_in arrived while busy and was dropped
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for eop_in
// S_DRAIN  | counting down engine pipeline latency
// S_CAPT   | sample match_in into pending, pulse eng_clr
// S_REPORT | present lowest pending ID, pop it on handshake
// S_DONE   | pulse done, return to idle

module payload_match_reporter #(
  parameter int NUM_ENGINES = 64,
  parameter int ID_W        = 8,
  parameter int DRAIN_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENGINES-1:0] match_in,
  input  logic                   eop_in,
  output logic                   eng_clr,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic                   rpt_last,
  output logic                   done,
  output logic [ID_W:0]          match_cnt,
  output logic                   busy,
  output logic                   err_eop_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_CAPT,
    S_REPORT,
    S_DONE
  } state_t;

  // The counter is loaded on the eop cycle, so one count is already spent.
  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYC == 0) ? 4'd0 : 4'(DRAIN_CYC - 1);
  localparam logic [ID_W:0] CNT_MAX = (ID_W + 1)'(NUM_ENGINES);
  localparam logic [NUM_ENGINES-1:0] ONE = NUM_ENGINES'(1);

  state_t state, state_nxt;

  logic [3:0]             drain_cnt;
  logic [NUM_ENGINES-1:0] pending;
  logic [NUM_ENGINES-1:0] pending_dec;
  logic [ID_W-1:0]        low_idx;
  logic                   single_bit;
  logic                   handshake;

  // pending & (pending - 1) drops the lowest set bit; it is zero exactly when
  // at most one bit is set.
  assign pending_dec = pending - ONE;
  assign single_bit  = (pending != '0) && ((pending & pending_dec) == '0);
  assign handshake   = (state == S_REPORT) && rpt_ready;

  // LSB-first priority encoder: scan downward so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = ID_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (eop_in) state_nxt = (DRAIN_CYC == 0) ? S_CAPT : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == 4'd0) state_nxt = S_CAPT;
      end
      S_CAPT: begin
        state_nxt = (match_in == '0) ? S_DONE : S_REPORT;
      end
      S_REPORT: begin
        if (rpt_ready && single_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    eng_clr   = 1'b0;
    rpt_valid = 1'b0;
    rpt_id    = '0;
    rpt_last  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_CAPT:   eng_clr = 1'b1;
      S_REPORT: begin
        rpt_valid = 1'b1;
        rpt_id    = low_idx;
        rpt_last  = single_bit;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: drain timer, captured match set, report count, drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt    <= 4'd0;
      pending      <= '0;
      match_cnt    <= '0;
      err_eop_drop <= 1'b0;
    end else begin
      if (state == S_IDLE && eop_in) begin
        drain_cnt <= DRAIN_LOAD;
      end else if (state == S_DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end

      if (state == S_CAPT) begin
        pending   <= match_in;
        match_cnt <= '0;
      end else if (handshake) begin
        pending <= pending & pending_dec;
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + (ID_W + 1)'(1);
      end

      if (eop_in && state != S_IDLE) err_eop_drop <= 1'b1;
    end
  end

endmodule

// File: doc/payload_match_reporter.md
# payload_match_reporter

Collects the sticky match outputs of a bank of payload regex engines at the end of each payload and reports the IDs of the matching engines one at a time over a valid/ready stream. It sits downstream of the engine bank and drives the start-of-data clear (`sod`) that arms the engines for the next payload. The engines detect matches; this block reads and reports them.

## Interface
- `NUM_ENGINES`, 64: width of the match vector, one bit per engine; engine index equals reported ID.
- `ID_W`, 8: width of `rpt_id`; must satisfy 2^ID_W ≥ NUM_ENGINES.
- `DRAIN_CYC`, 2: cycles to wait after `eop_in` before sampling, covering engine pipeline latency; range 0..15.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `match_in`, input, NUM_ENGINES: sticky engine `out` lines.
- `eop_in`, input, 1: one-cycle pulse; the last payload byte has been presented to the engines with `en` high.
- `eng_clr`, output, 1: one-cycle clear to the engine `sod` inputs.
- `rpt_valid`, output, 1: report ID valid.
- `rpt_ready`, input, 1: consumer accepts the ID.
- `rpt_id`, output, ID_W: index of a matching engine.
- `rpt_last`, output, 1: qualifies `rpt_valid`; this is the final ID for the payload.
- `done`, output, 1: one-cycle pulse when reporting for the payload is complete.
- `match_cnt`, output, ID_W+1: number of IDs reported for the last payload; valid while `done` is high and held until the next capture.
- `busy`, output, 1: high in every state except IDLE.
- `err_eop_drop`, output, 1: sticky flag; an `eop_in` arrived while busy.

## Operation
- States: IDLE, DRAIN, CAPT, REPORT, DONE.
- IDLE: when `eop_in` is high, go to DRAIN and load the drain counter with DRAIN_CYC−1. If DRAIN_CYC=0, go straight to CAPT.
- DRAIN: decrement the counter each cycle. When it reaches 0, go to CAPT.
- CAPT (one cycle):
  - Register `match_in` into `pending` and clear `match_cnt` to 0.
  - Assert `eng_clr` in this cycle.
  - If the sampled value is 0, go to DONE; otherwise go to REPORT.
- REPORT:
  - `rpt_id` is the lowest set bit index of `pending` (priority encode, LSB first).
  - `rpt_last` is high when `pending` has exactly one bit set.
  - `rpt_valid` is high.
  - On a handshake (`rpt_valid & rpt_ready`): clear that bit in `pending` and increment `match_cnt`. If `rpt_last` was high, go to DONE.
  - `match_in` is ignored while in REPORT.
- DONE (one cycle): pulse `done`, then go to IDLE.
- `eop_in` outside IDLE is dropped and sets `err_eop_drop`. It never restarts or extends the current sequence.
- Arithmetic:
  - `match_cnt` maximum is NUM_ENGINES and never wraps.
  - The drain counter is 4 bits.
  - Unused high bits of `rpt_id` are 0.

## Timing
- Reset values: state IDLE; `pending`=0, `match_cnt`=0; `eng_clr`, `rpt_valid`, `rpt_last`, `done`, `busy`, `err_eop_drop` all 0; `rpt_id`=0.
- With `eop_in` high at cycle T:
  - Capture and `eng_clr` occur at cycle T+1+DRAIN_CYC.
  - The first `rpt_valid` is at T+2+DRAIN_CYC.
- With `rpt_ready` held high, IDs go out one per cycle, with no bubbles between IDs.
- `done` is high the cycle after the final handshake. For an empty capture, `done` is high the cycle after CAPT.
- Stream rules:
  - Once `rpt_valid` is high, `rpt_id` and `rpt_last` stay stable until the handshake.
  - `rpt_valid` never drops without a handshake.
- `busy` goes high the cycle after `eop_in` and falls in the cycle after DONE. A new `eop_in` is accepted in the cycle `busy` is low.
- `eop_in` coincident with the `done` cycle is dropped and flagged.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all reset values.
  - No `done` and no `eng_clr` are produced.
  - Pending IDs are discarded.

## Test plan
- Single match, DRAIN_CYC=2, `match_in`=bit 5 only, `eop_in` at cycle 10:
  - `eng_clr` at cycle 13.
  - `rpt_valid` at cycle 14 with `rpt_id`=5 and `rpt_last`=1.
  - `done` at cycle 15 with `match_cnt`=1.
- Multi-match with backpressure, `match_in` bits {0,7,63}, `rpt_ready` toggling 1,0,0,1,1:
  - IDs 0, 7, 63 in order; `rpt_last` only on 63.
  - IDs stay stable while stalled; `match_cnt`=3.
- Empty payload, `match_in`=0:
  - `eng_clr` at T+3, `done` at T+4, `match_cnt`=0.
  - `rpt_valid` never asserts.
- DRAIN_CYC=0 with all 64 bits set and `rpt_ready`=1:
  - Capture at T+1.
  - IDs 0..63 on consecutive cycles; `match_cnt`=64.
- `eop_in` pulsed during REPORT:
  - `err_eop_drop`=1 and stays set.
  - The ongoing sequence completes unchanged.
- `reset` during REPORT after 2 of 4 IDs:
  - Next cycle: `rpt_valid`=0, `busy`=0, `match_cnt`=0.
  - No `done`.
  - A following `eop_in` works normally.
